// File: rtl/mux_8x1_rr_sched.sv
// Round-robin scheduler driving the select of a shared 8:1 mux.
// A grant lasts until the owner drops its request, the hold limit expires, or the scheduler is disabled.
module mux_8x1_rr_sched #(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned HOLD_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       sel_valid,
    output logic       busy
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e            state_q, state_d;
    logic [7:0]        gnt_q, gnt_d;
    logic [2:0]        sel_q, sel_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic [2:0] base;
    logic [2:0] win;
    logic [2:0] idx;
    logic       found;
    logic       release_now;

    // Rotating priority search. While granting, the search starts one past the
    // owner, so the owner ranks last and wins again only as the sole requester.
    always_comb begin
        base  = (state_q == StGrant) ? sel_q + 3'd1 : ptr_q;
        win   = 3'd0;
        found = 1'b0;
        idx   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            idx = base + 3'(i);
            if (req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign release_now = (state_q == StGrant) &&
                         (!req[sel_q] || (hold_q == HOLD_W'(MAX_HOLD - 1)) || !en);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        unique case (state_q)
            StIdle: begin
                if (en && found) begin
                    state_d = StGrant;
                    gnt_d   = 8'd1 << win;
                    sel_d   = win;
                    hold_d  = '0;
                end
            end
            StGrant: begin
                if (release_now) begin
                    ptr_d  = sel_q + 3'd1;
                    hold_d = '0;
                    if (en && found) begin
                        gnt_d = 8'd1 << win;
                        sel_d = win;
                    end else begin
                        state_d = StIdle;
                        gnt_d   = 8'd0;
                    end
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            gnt_q   <= 8'd0;
            sel_q   <= 3'd0;
            ptr_q   <= 3'd0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign sel_valid = (state_q == StGrant);
    assign busy      = (state_q == StGrant);

endmodule

// File: tb/tb_mux_8x1_rr_sched.sv
// Directed bench for mux_8x1_rr_sched with MAX_HOLD=4.
// Expected grants are hand-derived from the round-robin rules.
module tb_mux_8x1_rr_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       sel_valid;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mux_8x1_rr_sched #(
        .MAX_HOLD(4),
        .HOLD_W  (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .req      (req),
        .gnt      (gnt),
        .sel      (sel),
        .sel_valid(sel_valid),
        .busy     (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] eg, input logic [2:0] es,
                           input logic ev);
        chk({tag, " gnt"}, gnt, eg);
        chk({tag, " sel"}, {5'd0, sel}, {5'd0, es});
        chk({tag, " sel_valid"}, {7'd0, sel_valid}, {7'd0, ev});
        chk({tag, " busy"}, {7'd0, busy}, {7'd0, ev});
    endtask

    initial begin
        // Reset dominates even with requests pending
        rst = 1'b1; en = 1'b1; req = 8'hFF;
        step();
        chk_out("reset", 8'h00, 3'd0, 1'b0);

        // 1: single requester keeps the grant across hold expiries
        req = 8'h01; rst = 1'b0;
        step();
        chk_out("t1 first", 8'h01, 3'd0, 1'b1);
        for (int k = 0; k < 9; k++) begin
            step();
            chk_out("t1 hold", 8'h01, 3'd0, 1'b1);
        end

        // 2: all requesting, each owner exactly 4 cycles, continue until owner 5
        rst = 1'b1;
        step();
        rst = 1'b0; req = 8'hFF;
        for (int j = 0; j <= 52; j++) begin
            logic [2:0] own;
            own = 3'((j / 4) % 8);
            step();
            chk_out("t2 rr", 8'd1 << own, own, 1'b1);
        end

        // 3: owner 5 drops, ptr=6, req 0 and 2 -> 0,2,0
        req = 8'b0000_0101;
        for (int k = 0; k < 4; k++) begin
            step();
            chk_out("t3 own0", 8'h01, 3'd0, 1'b1);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            chk_out("t3 own2", 8'h04, 3'd2, 1'b1);
        end
        step();
        chk_out("t3 own0 again", 8'h01, 3'd0, 1'b1);

        // 4: go idle, then req[3] for two cycles
        req = 8'h00;
        step();
        chk_out("t4 idle", 8'h00, 3'd0, 1'b0);
        req = 8'h08;
        step();
        chk_out("t4 g1", 8'h08, 3'd3, 1'b1);
        step();
        chk_out("t4 g2", 8'h08, 3'd3, 1'b1);
        req = 8'h00;
        step();
        chk_out("t4 drop", 8'h00, 3'd3, 1'b0);

        // 5: grant 2, disable, stay idle while disabled, re-enable
        req = 8'h04;
        step();
        chk_out("t5 g2", 8'h04, 3'd2, 1'b1);
        en = 1'b0;
        step();
        chk_out("t5 en off", 8'h00, 3'd2, 1'b0);
        step();
        chk_out("t5 en off idle", 8'h00, 3'd2, 1'b0);
        en = 1'b1; req = 8'h0C;
        step();
        chk_out("t5 ptr past 2", 8'h08, 3'd3, 1'b1);

        // 6: owner 3 drops, 5 wins; reset mid-grant; ptr back to 0
        req = 8'h20;
        step();
        chk_out("t6 g5", 8'h20, 3'd5, 1'b1);
        rst = 1'b1;
        step();
        chk_out("t6 reset", 8'h00, 3'd0, 1'b0);
        rst = 1'b0; req = 8'hA1;
        step();
        chk_out("t6 after reset", 8'h01, 3'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
